// File: rtl/button_debouncer_if.sv
// Pushbutton pin plus its cleaned outputs: the debouncer is the slave,
// whatever drives the pin and consumes the pulses is the master.
interface button_debouncer_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces one raw pushbutton into a level and single-cycle press/release
// pulses. Define BTN_REPEAT_EN to build auto-repeat press pulses while held.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic                clk,
  input  logic                rst,
  button_debouncer_if.slave   btn
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic            IDLE_LVL = (BTN_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic             sync1_reg, sync2_reg;
  logic             btn_s;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             rpt_fire;

  // Sync flops idle at the pin's released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= IDLE_LVL;
      sync2_reg <= IDLE_LVL;
    end else begin
      sync1_reg <= btn.btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign btn_s = sync2_reg ^ IDLE_LVL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (btn_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (rpt_fire) begin
          press_next = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = HELD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = IDLE;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic             rpt_phase_reg, rpt_phase_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_reg   <= '0;
      rpt_phase_reg <= 1'b0;
    end else begin
      rpt_cnt_reg   <= rpt_cnt_next;
      rpt_phase_reg <= rpt_phase_next;
    end
  end

  // Phase 0 waits for the first repeat, phase 1 paces the following ones.
  always_comb begin
    rpt_cnt_next   = rpt_cnt_reg;
    rpt_phase_next = rpt_phase_reg;
    rpt_fire       = 1'b0;
    case (state_reg)
      IDLE, PRESS_WAIT: begin
        rpt_cnt_next   = '0;
        rpt_phase_next = 1'b0;
      end
      HELD: begin
        if (btn_s) begin
          if (rpt_cnt_reg == (rpt_phase_reg ? PERIOD_LAST : DELAY_LAST)) begin
            rpt_fire       = 1'b1;
            rpt_cnt_next   = '0;
            rpt_phase_next = 1'b1;
          end else begin
            rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign btn.btn_level     = level_reg;
  assign btn.press_pulse   = press_reg;
  assign btn.release_pulse = release_reg;
endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer against a run-length
// model of the debounce rules, plus literal pulse-timing expectations.
module tb_button_debouncer;
  localparam int DC  = 8;
  localparam int BAL = 1;
  localparam int RD  = 20;
  localparam int RP  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   press_q[$];
  int   release_q[$];

  button_debouncer_if bif ();

  button_debouncer #(
    .DEBOUNCE_CYCLES(DC),
    .BTN_ACTIVE_LOW (BAL),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
  endtask

  // Model: the pin reaches the decision logic two samples late; the level
  // flips after DC+1 consecutive samples that disagree with it.
  bit m_p1 = 0, m_p2 = 0;
  bit m_level = 0, m_press = 0, m_rel = 0;
  int m_run = 0;
  int m_rep = 0;
  bit m_rep_ph = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_p1 = 0; m_p2 = 0;
      m_level = 0; m_press = 0; m_rel = 0;
      m_run = 0; m_rep = 0; m_rep_ph = 0;
    end else begin
      bit s_now;
      bit was_stable;
      s_now = m_p2;
      m_p2  = m_p1;
      m_p1  = (BAL != 0) ? ~bif.btn_in : bif.btn_in;
      m_press = 0;
      m_rel   = 0;
      if (s_now != m_level) begin
        m_run++;
        if (m_run == DC + 1) begin
          m_level = s_now;
          m_run = 0;
          m_rep = 0;
          m_rep_ph = 0;
          if (s_now) m_press = 1;
          else       m_rel = 1;
        end
      end else begin
        was_stable = (m_run == 0);
        m_run = 0;
`ifdef BTN_REPEAT_EN
        if (m_level && was_stable) begin
          m_rep++;
          if (m_rep == (m_rep_ph ? RP : RD)) begin
            m_press = 1;
            m_rep = 0;
            m_rep_ph = 1;
          end
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (edge_n >= 1) begin
      chk("btn_level", int'(bif.btn_level), int'(m_level));
      chk("press_pulse", int'(bif.press_pulse), int'(m_press));
      chk("release_pulse", int'(bif.release_pulse), int'(m_rel));
      if (bif.press_pulse) press_q.push_back(edge_n);
      if (bif.release_pulse) release_q.push_back(edge_n);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pin(input bit pressed);
    bif.btn_in = (BAL != 0) ? ~pressed : pressed;
  endtask

  task automatic clear_q();
    press_q.delete();
    release_q.delete();
  endtask

  initial begin
    int e0, r0, last, rr, p;
    bit pv;
    int exp_rep[$];
    set_pin(0);
    rst = 1'b0;
    tick(3);
    chk("reset_level", int'(bif.btn_level), 0);
    chk("reset_press", int'(bif.press_pulse), 0);
    chk("reset_release", int'(bif.release_pulse), 0);
    rst = 1'b1;
    tick(20);

    // Clean press, held 40 clocks.
    clear_q();
    e0 = edge_n;
    set_pin(1);
    tick(40);
    r0 = edge_n;
    set_pin(0);
    tick(20);
    chk("clean_press_edge", (press_q.size() > 0) ? press_q[0] - e0 : -1, 11);
`ifdef BTN_REPEAT_EN
    chk("clean_press_count", press_q.size(), 3);
`else
    chk("clean_press_count", press_q.size(), 1);
`endif
    chk("clean_release_count", release_q.size(), 1);
    chk("clean_release_edge", (release_q.size() > 0) ? release_q[0] - r0 : -1, 11);
    chk("clean_level_after", int'(bif.btn_level), 0);

    // Bounce: toggle every 3 clocks, finishing pressed.
    clear_q();
    pv = 0;
    last = 0;
    for (int i = 0; i < 11; i++) begin
      pv = ~pv;
      set_pin(pv);
      last = edge_n;
      if (i < 10) tick(3);
    end
    tick(20);
    chk("bounce_press_count", press_q.size(), 1);
    chk("bounce_press_edge", (press_q.size() > 0) ? press_q[0] - last : -1, 11);
    chk("bounce_release_count", release_q.size(), 0);

    // Glitch while held.
    clear_q();
    set_pin(0);
    tick(5);
    set_pin(1);
    tick(15);
    chk("glitch_level", int'(bif.btn_level), 1);
    chk("glitch_release_count", release_q.size(), 0);
`ifndef BTN_REPEAT_EN
    chk("glitch_press_count", press_q.size(), 0);
`endif
    set_pin(0);
    tick(20);

    // Reset during PRESS_WAIT with the button still held.
    clear_q();
    set_pin(1);
    tick(5);
    rst = 1'b0;
    tick(2);
    chk("midrst_level", int'(bif.btn_level), 0);
    chk("midrst_press", int'(bif.press_pulse), 0);
    tick(1);
    rst = 1'b1;
    rr = edge_n;
    tick(20);
    chk("midrst_press_count", press_q.size(), 1);
    chk("midrst_press_edge", (press_q.size() > 0) ? press_q[0] - rr : -1, 11);
    chk("midrst_release_count", release_q.size(), 0);
    set_pin(0);
    tick(20);

    // Long hold: auto-repeat behaviour.
    clear_q();
    e0 = edge_n;
    set_pin(1);
    tick(76);
    set_pin(0);
    tick(20);
    p = e0 + 11;
    exp_rep.delete();
    exp_rep.push_back(p);
`ifdef BTN_REPEAT_EN
    for (int k = 20; k <= 60; k += 10) exp_rep.push_back(p + k);
`endif
    chk("hold_press_count", press_q.size(), exp_rep.size());
    foreach (exp_rep[k])
      chk("hold_press_edge", (k < press_q.size()) ? press_q[k] : -1, exp_rep[k]);
    chk("hold_release_count", release_q.size(), 1);

    // Random bouncy pin with occasional resets; the model checks every cycle.
    pv = 0;
    for (int i = 0; i < 150; i++) begin
      pv = ~pv;
      set_pin(pv);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(10, 40));
      else tick($urandom_range(1, 12));
      if ($urandom_range(0, 25) == 0) begin
        rst = 1'b0;
        tick($urandom_range(1, 3));
        rst = 1'b1;
      end
    end
    set_pin(0);
    tick(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
